// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request and result handshake bundle between the execute stage and muldiv_unit.
interface muldiv_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             valid;
    logic             ready;
    logic [2:0]       op;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [TAG_W-1:0] tag;
    logic             res_valid;
    logic             res_ready;
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] res_tag;
    modport master (output valid, op, rs1, rs2, tag, res_ready, input ready, res_valid, res, res_tag);
    modport slave (input valid, op, rs1, rs2, tag, res_ready, output ready, res_valid, res, res_tag);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: bit-serial RV32M/RV64M multiply (shift-add) and divide (restoring) unit.
// LIANG_MDU_SINGLE_CYCLE_MUL_EN swaps the iterative multiply for a combinational one.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input logic         clk_i,
    input logic         rst_i,
    input logic         flush_i,
    muldiv_unit_if.slave io
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   b_q, b_d, res_q, res_d;
    logic              is_div, sgn1, sgn2, s1, s2, div0, ovf, accept, qbit;
    logic [XLEN-1:0]   a_mag, b_mag, special, div_val, mul_res, div_res;
    logic [XLEN:0]     sum, shifted, trial, rem_step;
    logic [2*XLEN-1:0] acc_step, prod;
    assign is_div  = io.op[2];
    assign sgn1    = is_div ? ~io.op[0] : (io.op == 3'd1 || io.op == 3'd2);
    assign sgn2    = is_div ? ~io.op[0] : (io.op == 3'd1);
    assign s1      = sgn1 & io.rs1[XLEN-1];
    assign s2      = sgn2 & io.rs2[XLEN-1];
    assign a_mag   = s1 ? -io.rs1 : io.rs1;
    assign b_mag   = s2 ? -io.rs2 : io.rs2;
    assign div0    = is_div && io.rs2 == '0;
    assign ovf     = is_div && !io.op[0] && io.rs1 == {1'b1, {(XLEN-1){1'b0}}} && &io.rs2;
    assign special = div0 ? (io.op[1] ? io.rs1 : '1) : (io.op[1] ? '0 : io.rs1);
    assign io.ready     = state_q == IDLE || (state_q == DONE && io.res_ready);
    assign accept       = io.valid && io.ready && !flush_i;
    assign io.res_valid = state_q == DONE;
    assign io.res       = res_q;
    assign io.res_tag   = tag_q;
    // One multiplier bit consumed from acc[0], or one dividend bit shifted into the remainder.
    assign sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign shifted  = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
    assign trial    = shifted - {1'b0, b_q};
    assign qbit     = ~trial[XLEN];
    assign rem_step = qbit ? trial : shifted;
    assign acc_step = op_q[2] ? {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], qbit} : {sum, acc_q[XLEN-1:1]};
    assign prod     = neg_q ? -acc_step : acc_step;
    assign mul_res  = op_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign div_val  = op_q[1] ? rem_step[XLEN-1:0] : acc_step[XLEN-1:0];
    assign div_res  = neg_q ? -div_val : div_val;
`ifdef LIANG_MDU_SINGLE_CYCLE_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{s1}}, io.rs1} * {{XLEN{s2}}, io.rs2};
`endif
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tag_d   = tag_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        b_d     = b_q;
        res_d   = res_q;
        if (flush_i) state_d = IDLE;
        else if (accept) begin
            op_d    = io.op;
            tag_d   = io.tag;
            neg_d   = (is_div && io.op[1]) ? s1 : s1 ^ s2;
            cnt_d   = CW'(XLEN - 1);
            acc_d   = {{XLEN{1'b0}}, a_mag};
            rem_d   = '0;
            b_d     = b_mag;
            state_d = BUSY;
            if (div0 || ovf) begin
                res_d   = special;
                state_d = DONE;
            end
`ifdef LIANG_MDU_SINGLE_CYCLE_MUL_EN
            if (!is_div) begin
                res_d   = io.op == 3'd0 ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
                state_d = DONE;
            end
`endif
        end else if (state_q == DONE && io.res_ready) state_d = IDLE;
        else if (state_q == BUSY) begin
            acc_d = acc_step;
            rem_d = rem_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                state_d = DONE;
                res_d   = op_q[2] ? div_res : mul_res;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            tag_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int tests = 0;
    int fails = 0;
`ifdef LIANG_MDU_SINGLE_CYCLE_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    muldiv_unit_if #(.XLEN(32), .TAG_W(5)) io ();
    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (.clk_i(clk), .rst_i(rst), .flush_i(flush), .io(io));
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", name, obs, want);
        end
    endtask
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            3'd0, 3'd1: p = sa * sb;
            3'd2:       p = sa * ub;
            3'd3:       p = ua * ub;
            default:    p = '0;
        endcase
        if (!op[2]) return op == 3'd0 ? p[31:0] : p[63:32];
        if (b == 32'd0) return op[1] ? a : 32'hFFFFFFFF;
        if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'd0 : a;
        p = op[0] ? (op[1] ? ua % ub : ua / ub) : (op[1] ? sa % sb : sa / sb);
        return p[31:0];
    endfunction
    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MUL_LAT;
        if (b == 32'd0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
        return 33;
    endfunction
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tg);
        int lat;
        check({name, " ready"}, 64'(io.ready), 64'd1);
        io.valid = 1'b1;
        io.op = op;
        io.rs1 = a;
        io.rs2 = b;
        io.tag = tg;
        step();
        io.valid = 1'b0;
        lat = 1;
        while (!io.res_valid && lat < 100) begin
            step();
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(ref_lat(op, a, b)));
        check({name, " res"}, 64'(io.res), 64'(ref_res(op, a, b)));
        check({name, " tag"}, 64'(io.res_tag), 64'(tg));
        io.res_ready = 1'b1;
        step();
        io.res_ready = 1'b0;
        check({name, " idle"}, 64'(io.res_valid), 64'd0);
    endtask
    task automatic abort(input string name, input bit use_rst);
        bit seen;
        io.valid = 1'b1;
        io.op = 3'd5;
        io.rs1 = 32'd100;
        io.rs2 = 32'd7;
        io.tag = 5'd7;
        step();
        io.valid = 1'b0;
        repeat (9) step();
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        step();
        rst = 1'b0;
        flush = 1'b0;
        check({name, " ready"}, 64'(io.ready), 64'd1);
        check({name, " valid"}, 64'(io.res_valid), 64'd0);
        if (use_rst) check({name, " res"}, 64'(io.res), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            step();
            if (io.res_valid) seen = 1'b1;
        end
        check({name, " no result"}, 64'(seen), 64'd0);
    endtask
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction
    initial begin
        int lat;
        io.valid = 1'b0;
        io.res_ready = 1'b0;
        io.op = '0;
        io.rs1 = '0;
        io.rs2 = '0;
        io.tag = '0;
        repeat (3) step();
        rst = 1'b0;
        check("reset res_valid", 64'(io.res_valid), 64'd0);
        check("reset res", 64'(io.res), 64'd0);
        check("reset res_tag", 64'(io.res_tag), 64'd0);
        check("reset ready", 64'(io.ready), 64'd1);
        run_op("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
        run_op("mulh", 3'd1, 32'h80000000, 32'h80000000, 5'd1);
        run_op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
        run_op("div", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd4);
        run_op("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd6);
        run_op("divu", 3'd5, 32'd100, 32'd7, 5'd8);
        run_op("remu", 3'd7, 32'd100, 32'd7, 5'd9);
        run_op("div0", 3'd4, 32'd5, 32'd0, 5'd10);
        run_op("remu0", 3'd7, 32'd5, 32'd0, 5'd11);
        run_op("div ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12);
        run_op("rem ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13);
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            run_op("rand", op, pick(), pick(), 5'($urandom_range(0, 31)));
        end
        // Backpressure: result held for 10 cycles, then consumed alongside a new request.
        io.valid = 1'b1;
        io.op = 3'd3;
        io.rs1 = 32'hFFFFFFFF;
        io.rs2 = 32'hFFFFFFFF;
        io.tag = 5'd12;
        step();
        io.valid = 1'b0;
        for (int i = 0; i < 100 && !io.res_valid; i++) step();
        check("bp valid", 64'(io.res_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp res", 64'(io.res), 64'hFFFFFFFE);
            check("bp tag", 64'(io.res_tag), 64'd12);
            check("bp ready", 64'(io.ready), 64'd0);
            step();
        end
        io.res_ready = 1'b1;
        io.valid = 1'b1;
        io.op = 3'd5;
        io.rs1 = 32'd9;
        io.rs2 = 32'd3;
        io.tag = 5'd21;
        #1;
        check("bp ready comb", 64'(io.ready), 64'd1);
        step();
        io.valid = 1'b0;
        io.res_ready = 1'b0;
        check("bp busy", 64'(io.res_valid), 64'd0);
        lat = 1;
        while (!io.res_valid && lat < 100) begin
            step();
            lat++;
        end
        check("bp latency", 64'(lat), 64'd33);
        check("bp divu", 64'(io.res), 64'd3);
        check("bp divu tag", 64'(io.res_tag), 64'd21);
        io.res_ready = 1'b1;
        step();
        io.res_ready = 1'b0;
        abort("flush", 1'b0);
        abort("reset", 1'b1);
        run_op("after abort", 3'd5, 32'd100, 32'd7, 5'd30);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised, multi-cycle RV32M/RV64M multiply/divide unit in the execute stage, next to the single-cycle ALU. It accepts one operation at a time over a valid/ready handshake and iterates one bit per cycle, using a shift-add multiplier or a restoring divider. It returns the result and destination tag over a second valid/ready handshake, and supports pipeline flush.

## Interface
Parameters:
- XLEN, 32: operand/result width (32 or 64).
- TAG_W, 5: width of the pass-through destination tag.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  abort current operation, synchronous.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request.
- op_i  in  3  operation, RV funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_i, rs2_i  in  XLEN  operands.
- tag_i  in  TAG_W  destination tag.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts result.
- res_o  out  XLEN  result.
- res_tag_o  out  TAG_W  tag captured with the request.

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE. After reset, res_valid_o=0, res_o=0, res_tag_o=0 and ready_o=1.
- ready_o = (state==IDLE) | (state==DONE & res_ready_i). ready_o is combinational on res_ready_i, which allows back-to-back operations.
- Accept when valid_i & ready_o. On acceptance, capture op_i, tag_i and the operand magnitudes. Also capture the result sign flags:
  - MUL*: product sign = s1^s2. s1 is the rs1 sign for MULH/MULHSU. s2 is the rs2 sign for MULH only.
  - DIV/REM: quotient sign = s1^s2; remainder sign = s1. These apply only to the signed ops.
- Iteration counter loads XLEN-1 on acceptance.
  - In BUSY, perform one step per cycle: a shift-add product bit, or a restoring quotient bit with remainder update.
  - Decrement the counter each step. The step taken at count 0 transitions to DONE.
- Transition to DONE registers the final result:
  - Negate per the sign flags.
  - MUL selects product[XLEN-1:0]; MULH* select product[2XLEN-1:XLEN].
  - DIV* select the quotient; REM* select the remainder.
- Special cases go IDLE→DONE directly, with no BUSY:
  - Divide by zero: quotient = all ones; remainder = rs1.
  - Signed overflow (DIV/REM with rs1 = most-negative, rs2 = -1): quotient = rs1; remainder = 0.
- DONE: res_valid_o=1. res_o and res_tag_o stay stable until res_valid_o & res_ready_i.
  - On handshake without a new request, go to IDLE.
  - On handshake with a simultaneous new request, go to BUSY, or to DONE for the special cases.
- Flush: flush_i=1 forces IDLE on the next edge from any state, and res_valid_o=0 next cycle. A request presented in the same cycle as flush_i is dropped. A result handshake in the flush cycle still counts as consumed.
- Priority: rst_i > flush_i > normal operation.
- Iterative datapath width: a 2XLEN product accumulator, plus an XLEN+1-bit partial remainder.

## Timing
- Acceptance cycle = C0.
- Normal ops: BUSY occupies C1..C_XLEN; res_valid_o=1 from C_{XLEN+1}. This is C33 for XLEN=32.
- Special-case division: res_valid_o=1 at C1.
- Sustained throughput with res_ready_i=1: one op per XLEN+1 cycles.
- Reset mid-operation: next cycle IDLE, res_valid_o=0, ready_o=1. No stale result is emitted.

## Configuration
- LIANG_MDU_SINGLE_CYCLE_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU compute a full 2XLEN signed/unsigned product combinationally at acceptance and go IDLE→DONE, with res_valid_o at C1.
  - Division is unchanged.
- Undefined: all multiplies use the iterative path with XLEN+1 latency, and no hardware multiplier is inferred.

## Test plan
- MUL, rs1=7, rs2=0xFFFFFFFD, tag=5 → res_o=0xFFFFFFEB, res_tag_o=5. res_valid_o rises at C33, or at C1 with the macro defined.
- High-product variants:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Signed and unsigned division:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with res_valid_o at C1:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Backpressure: hold res_ready_i=0 for 10 cycles in DONE → res_o and res_tag_o stable, ready_o=0. Then raise res_ready_i together with valid_i (DIVU 9/3) → accepted the same cycle, 3 returned 33 cycles later.
- Abort: flush_i at C10 of a DIVU → IDLE and ready_o=1 at C11, res_valid_o never rises. Repeat with rst_i at C10 → same response, res_o=0.
